// File: rtl/control_unit.sv
// control_unit: hardwired T-state sequencer (T0..T7 + HALT) driving the datapath strobes.
// Latency: one T-state per clock; wait states (T1 fetch, ld T6, st T7) stall until mem_done.
// Backpressure: mem_done is the only stall input; define CU_WAIT_TIMEOUT_EN to bound waits (TO_CYC).
module control_unit #(
  parameter int OPW    = 5,
  parameter int TO_CYC = 16
) (
  input  logic           clk,
  input  logic           rst,
  input  logic [OPW-1:0] opcode,
  input  logic           con,
  input  logic           mem_done,
  input  logic           start,
  output logic [2:0]     bus_src,
  output logic [1:0]     gr_sel,
  output logic [2:0]     alu_op,
  output logic           pc_in,
  output logic           ma_in,
  output logic           ir_in,
  output logic           a_in,
  output logic           c_in,
  output logic           r_in,
  output logic           con_in,
  output logic           md_rd,
  output logic           md_wr,
  output logic           md_bus,
  output logic           run,
  output logic           fault,
  output logic [2:0]     tstate
);

  typedef enum logic [3:0] {
    S_T0 = 4'd0, S_T1 = 4'd1, S_T2 = 4'd2, S_T3 = 4'd3,
    S_T4 = 4'd4, S_T5 = 4'd5, S_T6 = 4'd6, S_T7 = 4'd7,
    S_HALT = 4'd8
  } state_t;

  localparam logic [OPW-1:0] OP_NOP  = OPW'(0);
  localparam logic [OPW-1:0] OP_LD   = OPW'(1);
  localparam logic [OPW-1:0] OP_ST   = OPW'(3);
  localparam logic [OPW-1:0] OP_LA   = OPW'(5);
  localparam logic [OPW-1:0] OP_BR   = OPW'(8);
  localparam logic [OPW-1:0] OP_ADD  = OPW'(12);
  localparam logic [OPW-1:0] OP_ADDI = OPW'(13);
  localparam logic [OPW-1:0] OP_SUB  = OPW'(14);
  localparam logic [OPW-1:0] OP_AND  = OPW'(20);
  localparam logic [OPW-1:0] OP_OR   = OPW'(22);
  localparam logic [OPW-1:0] OP_NOT  = OPW'(24);
  localparam logic [OPW-1:0] OP_STOP = OPW'(31);

  state_t state;

  // Opcode classes; opcode is only meaningful from T3 onward.
  logic is_alu3, is_addi, is_la, is_not, is_ld, is_st, is_br, is_nop, is_stop, is_legal;
  logic [2:0] alu3_op;
  logic in_wait;
  logic to_hit;

  assign is_alu3  = (opcode == OP_ADD) || (opcode == OP_SUB) || (opcode == OP_AND) || (opcode == OP_OR);
  assign is_addi  = (opcode == OP_ADDI);
  assign is_la    = (opcode == OP_LA);
  assign is_not   = (opcode == OP_NOT);
  assign is_ld    = (opcode == OP_LD);
  assign is_st    = (opcode == OP_ST);
  assign is_br    = (opcode == OP_BR);
  assign is_nop   = (opcode == OP_NOP);
  assign is_stop  = (opcode == OP_STOP);
  assign is_legal = is_alu3 | is_addi | is_la | is_not | is_ld | is_st | is_br | is_nop | is_stop;

  assign alu3_op = (opcode == OP_ADD) ? 3'd1 :
                   (opcode == OP_SUB) ? 3'd2 :
                   (opcode == OP_AND) ? 3'd3 : 3'd4;

  assign in_wait = (state == S_T1) || ((state == S_T6) && is_ld) || ((state == S_T7) && is_st);

`ifdef CU_WAIT_TIMEOUT_EN
  localparam int TCW = $clog2(TO_CYC + 1);
  logic [TCW-1:0] wait_cnt;

  // The TO_CYC-th stalled cycle in a wait state aborts to HALT.
  assign to_hit = in_wait && !mem_done && (wait_cnt == TCW'(TO_CYC - 1));

  // Count stalled cycles; cleared whenever a wait state is left or not occupied.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      wait_cnt <= '0;
    end else if (!in_wait || mem_done || to_hit) begin
      wait_cnt <= '0;
    end else begin
      wait_cnt <= wait_cnt + TCW'(1);
    end
  end
`else
  assign to_hit = 1'b0;
`endif

  // State sequencing plus the sticky fault flag.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state <= S_T0;
      fault <= 1'b0;
    end else if (to_hit) begin
      state <= S_HALT;
      fault <= 1'b1;
    end else begin
      case (state)
        S_T0: state <= S_T1;
        S_T1: if (mem_done) state <= S_T2;
        S_T2: state <= S_T3;
        S_T3: begin
          if (!is_legal) begin
            state <= S_HALT;
            fault <= 1'b1;
          end else if (is_stop) begin
            state <= S_HALT;
          end else if (is_nop) begin
            state <= S_T0;
          end else begin
            state <= S_T4;
          end
        end
        S_T4: state <= (is_not || is_br) ? S_T0 : S_T5;
        S_T5: state <= (is_ld || is_st) ? S_T6 : S_T0;
        S_T6: if (is_st || mem_done) state <= S_T7;
        S_T7: if (!is_st || mem_done) state <= S_T0;
        S_HALT: if (start) state <= S_T0;
        default: state <= S_T0;
      endcase
    end
  end

  // Moore decode of strobes; everything is forced low while reset is held.
  always_comb begin
    bus_src = 3'd0;
    gr_sel  = 2'd0;
    alu_op  = 3'd0;
    pc_in   = 1'b0;
    ma_in   = 1'b0;
    ir_in   = 1'b0;
    a_in    = 1'b0;
    c_in    = 1'b0;
    r_in    = 1'b0;
    con_in  = 1'b0;
    md_rd   = 1'b0;
    md_wr   = 1'b0;
    md_bus  = 1'b0;
    if (rst) begin
      case (state)
        S_T0: begin bus_src = 3'd1; ma_in = 1'b1; alu_op = 3'd6; c_in = 1'b1; md_rd = 1'b1; end
        S_T1: begin bus_src = 3'd2; pc_in = 1'b1; end
        S_T2: begin bus_src = 3'd3; ir_in = 1'b1; end
        S_T3: begin
          if (is_alu3 || is_addi) begin
            gr_sel = 2'd2; bus_src = 3'd4; a_in = 1'b1;
          end else if (is_la || is_ld || is_st) begin
            gr_sel = 2'd2; bus_src = 3'd5; a_in = 1'b1;
          end else if (is_not) begin
            gr_sel = 2'd3; bus_src = 3'd4; alu_op = 3'd5; c_in = 1'b1;
          end else if (is_br) begin
            gr_sel = 2'd3; bus_src = 3'd4; con_in = 1'b1;
          end
        end
        S_T4: begin
          if (is_alu3) begin
            gr_sel = 2'd3; bus_src = 3'd4; alu_op = alu3_op; c_in = 1'b1;
          end else if (is_addi || is_la || is_ld || is_st) begin
            bus_src = 3'd7; alu_op = 3'd1; c_in = 1'b1;
          end else if (is_not) begin
            bus_src = 3'd2; gr_sel = 2'd1; r_in = 1'b1;
          end else if (is_br) begin
            gr_sel = 2'd2; bus_src = 3'd4; pc_in = con;
          end
        end
        S_T5: begin
          if (is_alu3 || is_addi || is_la) begin
            bus_src = 3'd2; gr_sel = 2'd1; r_in = 1'b1;
          end else if (is_ld) begin
            bus_src = 3'd2; ma_in = 1'b1; md_rd = 1'b1;
          end else if (is_st) begin
            bus_src = 3'd2; ma_in = 1'b1;
          end
        end
        S_T6: if (is_st) begin gr_sel = 2'd1; bus_src = 3'd4; md_bus = 1'b1; md_wr = 1'b1; end
        S_T7: if (is_ld) begin bus_src = 3'd3; gr_sel = 2'd1; r_in = 1'b1; end
        default: ;
      endcase
    end
  end

  // Status: running unless halted; HALT reports T-index 0.
  always_comb begin
    run    = (state != S_HALT);
    tstate = (state == S_HALT) ? 3'd0 : state[2:0];
  end

endmodule

// File: doc/control_unit.md
CONTROL_UNIT -- requirements
Module: control_unit

Interface
REQ-001 Parameter OPW, default 5: opcode width; matches the instruction register's to_control_unit output.
REQ-002 Parameter TO_CYC, default 16: memory-wait timeout in cycles; used only when CU_WAIT_TIMEOUT_EN is defined.
REQ-003 The port list SHALL be the following, one port per line, clock and reset first; one clock; reset is asynchronous and active-low.
- clk  in  1  single system clock; all state changes on its rising edge.
- rst  in  1  asynchronous, active-low reset.
- opcode  in  OPW  instruction opcode from the IR.
- con  in  1  branch condition from the CON logic.
- mem_done  in  1  memory-cycle complete.
- start  in  1  leave HALT.
- bus_src  out  3  bus driver select: 0 none, 1 PC, 2 C, 3 MD, 4 R, 5 BA, 6 c1, 7 c2.
- gr_sel  out  2  register field select: 0 none, 1 Gra, 2 Grb, 3 Grc.
- alu_op  out  3  ALU operation: 0 pass, 1 ADD, 2 SUB, 3 AND, 4 OR, 5 NOT, 6 INC4.
- pc_in, ma_in, ir_in, a_in, c_in, r_in, con_in  out  1 each  register load strobes.
- md_rd, md_wr, md_bus  out  1 each  memory read, memory write, MD loads from bus.
- run  out  1  processor running.
- fault  out  1  illegal opcode or timeout; sticky until reset.
- tstate  out  3  current T-state index, for debug.

Function
REQ-004 The FSM SHALL have states T0..T7 and HALT; outside wait stalls, each T-state lasts exactly one clock.
REQ-005 All outputs SHALL be Moore-decoded from the state register and opcode; the only exception is pc_in in br/T4, which also depends on con.
REQ-006 Fetch sequence:
- T0: bus_src=PC, ma_in, alu_op=INC4, c_in, md_rd.
- T1: bus_src=C, pc_in; hold in T1 while mem_done=0.
- T2: bus_src=MD, ir_in.
REQ-007 Execute sequences, with opcode stable from T3 onward:
- add 12 / sub 14 / and 20 / or 22: T3 Grb R->A; T4 Grc R, op, c_in; T5 C->Gra r_in, end.
- addi 13 / la 5: T3 Grb (la: BA) ->A; T4 c2, ADD, c_in; T5 C->Gra r_in, end.
- not 24: T3 Grc R, NOT, c_in; T4 C->Gra r_in, end.
- ld 1: T3 Grb BA->A; T4 c2 ADD c_in; T5 C->ma_in md_rd; T6 wait mem_done; T7 MD->Gra r_in, end.
- st 3: T3 Grb BA->A; T4 c2 ADD c_in; T5 C->ma_in; T6 Gra R, md_bus, md_wr; T7 wait mem_done, end.
- br 8: T3 Grc R, con_in; T4 Grb R, pc_in only if con=1, end.
- nop 0: T3 end.
- stop 31: T3 -> HALT.
REQ-008 "end" SHALL mean the next state is T0.
REQ-009 A wait state SHALL hold all of its strobes asserted until the cycle in which mem_done=1, then advance.
REQ-010 Any opcode not listed in REQ-007 SHALL set fault=1 and enter HALT at T3.
REQ-011 In HALT: run=0 and all strobes are 0; start=1 moves to T0 next cycle. Does not clear fault.
REQ-012 start SHALL be ignored in every state except HALT.
REQ-013 mem_done SHALL be ignored in every state that is not a wait state.

Reset
REQ-014 rst=0 SHALL immediately force state T0, run=1, fault=0, and all strobes 0, including mid-instruction and mid-wait.
REQ-015 The first rising edge after rst deasserts SHALL execute T0 normally; no outputs are asserted while rst=0.

Configuration
REQ-016 With CU_WAIT_TIMEOUT_EN defined, a counter SHALL count cycles spent in any wait state; on reaching TO_CYC it sets fault=1 and enters HALT. The counter clears when a wait state is exited.
REQ-017 Without CU_WAIT_TIMEOUT_EN, wait states SHALL wait indefinitely, no counter is synthesized, and fault reports only illegal opcodes.

Verification
REQ-018 Reset: hold rst=0 mid-ld at T6 -> all strobes 0, tstate=0; release -> T0 outputs bus_src=1, ma_in=1, c_in=1, md_rd=1, alu_op=6.
REQ-019 add: opcode=12, mem_done=1 -> tstate sequence 0,1,2,3,4,5,0 with r_in=1 only at T5, alu_op=1 at T4.
REQ-020 ld: opcode=1, mem_done low for 3 cycles in T6 -> T6 held 4 cycles total, then T7 with bus_src=3, r_in=1.
REQ-021 br: opcode=8, con=1 -> pc_in=1 at T4; repeat with con=0 -> pc_in=0 at T4; both return to T0.
REQ-022 stop/illegal: opcode=31 -> HALT, run=0; start pulse -> T0, run=1. Opcode=7 -> fault=1, HALT.
REQ-023 Timeout (macro defined, TO_CYC=16): mem_done=0 in T1 -> fault=1 and HALT after 16 cycles; macro undefined -> remains in T1 and fault=0 after 100 cycles.
